// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: round-robin sequencer sharing one combinational ALU between two requesters
module alu_share_ctrl #(
  parameter int DW = 4,
  parameter int SW = 3,
  parameter int MAX_SEL = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic [DW-1:0] req0_a,
  input  logic [DW-1:0] req0_b,
  input  logic [SW-1:0] req0_sel,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic [DW-1:0] req1_a,
  input  logic [DW-1:0] req1_b,
  input  logic [SW-1:0] req1_sel,
  output logic          rsp0_valid,
  input  logic          rsp0_ready,
  output logic          rsp1_valid,
  input  logic          rsp1_ready,
  output logic [DW-1:0] rsp_data,
  output logic          rsp_zero,
  output logic          rsp_err,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [SW-1:0] alu_sel,
  input  logic [DW-1:0] alu_out,
  output logic          busy
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state;
  logic [DW-1:0] a_q, b_q;
  logic [SW-1:0] sel_q;
  logic id_q, rr_ptr, gnt1, rsp_fire;
  always_comb begin
    gnt1 = req1_valid && (!req0_valid || rr_ptr);
    req0_ready = state == IDLE && req0_valid && !gnt1;
    req1_ready = state == IDLE && gnt1;
    rsp0_valid = state == RESP && !id_q;
    rsp1_valid = state == RESP && id_q;
    rsp_fire = id_q ? rsp1_valid && rsp1_ready : rsp0_valid && rsp0_ready;
    alu_a = state == EXEC ? a_q : '0;
    alu_b = state == EXEC ? b_q : '0;
    alu_sel = state == EXEC ? sel_q : '0;
    busy = state != IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      a_q <= '0;
      b_q <= '0;
      sel_q <= '0;
      id_q <= 1'b0;
      rr_ptr <= 1'b0;
      rsp_data <= '0;
      rsp_zero <= 1'b0;
      rsp_err <= 1'b0;
    end else begin
      if (req0_ready || req1_ready) begin
        state <= EXEC;
        a_q <= gnt1 ? req1_a : req0_a;
        b_q <= gnt1 ? req1_b : req0_b;
        sel_q <= gnt1 ? req1_sel : req0_sel;
        id_q <= gnt1;
      end
      if (state == EXEC) begin
        state <= RESP;
        rsp_data <= alu_out;
        rsp_zero <= alu_out == '0;
        rsp_err <= sel_q > SW'(MAX_SEL);
      end
      if (rsp_fire) begin
        state <= IDLE;
        rr_ptr <= !id_q;
      end
    end
  end
endmodule

// File: doc/alu_share_ctrl.md
Name: alu_share_ctrl

Overview:
- Two-requester controller that shares the single combinational 4-bit ALU (ADD/SUB/AND/OR/NOT-A, select codes 0-4) between two clients.
- Sequences each operation:
  - accept the request,
  - drive the ALU from registered operands,
  - capture the result and zero flag,
  - return the response under valid/ready handshake.
- Arbitration is round-robin. The block sits between the core's issue logic (or a DMA/test port) and the ALU instance.

Parameters:
- DW, 4, operand/result width; must match the ALU width.
- SW, 3, ALU select width.
- MAX_SEL, 4, highest legal select code; codes above it are flagged as errors.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req0_valid  in  1  requester 0 has an op
- req0_ready  out  1  requester 0 op accepted this cycle
- req0_a  in  DW  operand A
- req0_b  in  DW  operand B
- req0_sel  in  SW  ALU select
- req1_valid, req1_ready, req1_a, req1_b, req1_sel: same as requester 0, for requester 1
- rsp0_valid  out  1  response for requester 0
- rsp0_ready  in  1  requester 0 takes response
- rsp1_valid  out  1  response for requester 1
- rsp1_ready  in  1  requester 1 takes response
- rsp_data  out  DW  result (shared; qualified by rspN_valid)
- rsp_zero  out  1  result == 0
- rsp_err  out  1  select code > MAX_SEL
- alu_a  out  DW  to ALU A
- alu_b  out  DW  to ALU B
- alu_sel  out  SW  to ALU select
- alu_out  in  DW  from ALU result
- busy  out  1  state != IDLE

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE; all ready/valid outputs 0; rsp_data=0; rsp_zero=0; rsp_err=0.
  - alu_a/alu_b/alu_sel=0; operand registers 0; rr_ptr=0 (requester 0 preferred).
  - Reset mid-operation discards the in-flight op; no response is issued after release.
- FSM states: IDLE -> EXEC -> RESP -> IDLE.
- IDLE:
  - reqN_ready is combinational: asserted only for the granted requester, only in IDLE, only when its valid=1.
  - Grant rule:
    - If only one valid, grant it.
    - If both valid, grant the requester indicated by rr_ptr.
  - On grant (valid&ready), latch a, b, sel and grant id, then go to EXEC.
  - No valid: stay in IDLE; ALU ports held at 0.
- EXEC (one cycle):
  - alu_a/alu_b/alu_sel driven from the latched registers.
  - At the clock edge, capture:
    - rsp_data <= alu_out
    - rsp_zero <= (alu_out==0)
    - rsp_err <= (sel>MAX_SEL)
  - Then go to RESP.
- RESP:
  - rspN_valid=1 for the granted id only.
  - rsp_data/zero/err are stable until the handshake.
  - On rspN_ready: go to IDLE and set rr_ptr to the other requester.
  - Without ready: hold indefinitely.
  - ALU ports return to 0.
  - Requests arriving in EXEC/RESP see ready=0 and must hold.
- Latency: accept at cycle T, rsp valid from T+2; minimum 3 cycles per op (no overlap).
- Arithmetic: modulo 2^DW as computed by the ALU; no carry/borrow reported. SUB wraps (3-5=4'hE).
- Illegal sel (5-7): passed through to the ALU; ALU yields 0, so rsp_data=0, rsp_zero=1, rsp_err=1. Not dropped.
- rr_ptr updates only on response completion, never on grant.
- Same-requester back-to-back: a new valid may be accepted in the IDLE cycle immediately after its response completes.
- Invariants:
  - At most one reqN_ready and at most one rspN_valid high in any cycle.
  - busy = (state!=IDLE).

Test Plan:
- Single op: after reset, req0 a=5 b=3 sel=0 -> req0_ready at T, alu_sel=0 during EXEC, rsp0_valid at T+2 with data=8, zero=0, err=0; rsp1_valid stays 0.
- Wraparound and zero: req1 a=3 b=5 sel=1 -> data=4'hE. Then req1 a=9 b=9 sel=1 -> data=0, zero=1.
- Round-robin: both valid continuously; req0 sel=2 a=C b=A, req1 sel=3 a=C b=A -> grants alternate 0,1,0,1 starting with 0. Responses are 8 (AND) and E (OR) respectively.
- Backpressure: rsp0_ready held low 5 cycles -> rsp0_valid, data, zero, err stable; busy=1; req1_ready=0 throughout; req1 granted only after the rsp0 handshake.
- Illegal/NOT: sel=3'b110 -> data=0, zero=1, err=1. sel=4 with a=4'h3 -> data=4'hC, err=0.
- Async reset: assert rst_n low during EXEC, mid-cycle -> all outputs 0 immediately, no response after release, next grant goes to requester 0.
